// File: rtl/dmem_pkg.sv
// Shared types and default address map for the CPU data-memory bus.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_MMIO = 2'd1,
        TGT_NONE = 2'd2
    } target_e;

    localparam logic [31:0] DEFAULT_RAM_BASE  = 32'h0001_0000;
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half/word from a target read word and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] q,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        unsigned_ext,
    output logic [31:0] data
);

    logic [15:0] low;

    always_comb begin
        low  = 16'(q >> {off, 3'b000});
        data = '0;
        case (size)
            SIZE_BYTE: data = unsigned_ext ? {24'h0, low[7:0]} : {{24{low[7]}}, low[7:0]};
            SIZE_HALF: data = unsigned_ext ? {16'h0, low}      : {{16{low[15]}}, low};
            SIZE_WORD: data = q;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_bus.sv
// CPU data-memory bus: decodes loads/stores onto a RAM and an MMIO window with a
// fixed one-cycle response and a hold register for a stalled response.
module dmem_bus
    import dmem_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = DEFAULT_RAM_BASE,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [13:0] ram_address,
    output logic [3:0]  ram_byteena,
    output logic        ram_clken,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic [13:0] mmio_address,
    output logic [3:0]  mmio_byteena,
    output logic        mmio_clken,
    output logic [31:0] mmio_data,
    output logic        mmio_wren,
    input  logic [31:0] mmio_q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state, state_next;
    logic [1:0]  off;
    target_e     tgt;
    logic        legal, accept;
    logic [3:0]  byteena;
    logic [31:0] store_data;

    target_e     p_tgt;
    logic [1:0]  p_off;
    size_e       p_size;
    logic        p_unsigned, p_write, p_error;
    logic [31:0] hold_rdata;
    logic        hold_error;
    logic [31:0] q_sel, aligned, fmt_rdata;

    assign off       = req_addr[1:0];
    assign rsp_valid = (state != ST_IDLE);
    assign req_ready = !rsp_valid || rsp_ready;
    // Gated by reset so a request held during reset cannot strobe a target.
    assign accept    = req_valid && req_ready && reset_n;

    always_comb begin
        if (req_addr[31:16] == RAM_BASE[31:16])       tgt = TGT_RAM;
        else if (req_addr[31:16] == MMIO_BASE[31:16]) tgt = TGT_MMIO;
        else                                          tgt = TGT_NONE;
    end

    always_comb begin
        byteena    = 4'b0000;
        store_data = req_wdata;
        legal      = (tgt != TGT_NONE);
        case (req_size)
            2'd0: begin
                byteena    = 4'b0001 << off;
                store_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                byteena    = 4'b0011 << off;
                store_data = {2{req_wdata[15:0]}};
                if (off[0]) legal = 1'b0;
            end
            2'd2: begin
                byteena = 4'b1111;
                if (off != 2'd0) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    assign ram_address  = req_addr[15:2];
    assign mmio_address = req_addr[15:2];
    assign ram_byteena  = byteena;
    assign mmio_byteena = byteena;
    assign ram_data     = store_data;
    assign mmio_data    = store_data;
    assign ram_clken    = accept && legal && (tgt == TGT_RAM);
    assign mmio_clken   = accept && legal && (tgt == TGT_MMIO);
    assign ram_wren     = ram_clken && req_write;
    assign mmio_wren    = mmio_clken && req_write;

    assign q_sel = (p_tgt == TGT_MMIO) ? mmio_q : ram_q;

    dmem_load_align u_align (
        .q            (q_sel),
        .off          (p_off),
        .size         (p_size),
        .unsigned_ext (p_unsigned),
        .data         (aligned)
    );

    assign fmt_rdata = (p_error || p_write) ? 32'h0 : aligned;

    always_comb begin
        rsp_rdata = 32'h0;
        rsp_error = 1'b0;
        if (state == ST_RESP) begin
            rsp_rdata = fmt_rdata;
            rsp_error = p_error;
        end else if (state == ST_HOLD) begin
            rsp_rdata = hold_rdata;
            rsp_error = hold_error;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RESP;
            ST_RESP, ST_HOLD: begin
                if (rsp_ready)             state_next = accept ? ST_RESP : ST_IDLE;
                else if (state == ST_RESP) state_next = ST_HOLD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            p_tgt      <= TGT_NONE;
            p_off      <= 2'd0;
            p_size     <= SIZE_BYTE;
            p_unsigned <= 1'b0;
            p_write    <= 1'b0;
            p_error    <= 1'b0;
            hold_rdata <= 32'h0;
            hold_error <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                p_tgt      <= tgt;
                p_off      <= off;
                p_size     <= size_e'(req_size);
                p_unsigned <= req_unsigned;
                p_write    <= req_write;
                p_error    <= !legal;
            end
            // The target q is only valid for one cycle, so capture it on the first stall.
            if (state == ST_RESP && !rsp_ready) begin
                hold_rdata <= fmt_rdata;
                hold_error <= p_error;
            end
        end
    end

endmodule
